dma_io_port: RTL

- I/O-side peripheral port that sits directly on the DMAC's device interface.
- Buffers bytes between a simple device-side push/pop interface and the DMAC.
- Drives DREQ and RDY toward the DMAC; responds to DACK/IOR/IOW; sources and sinks the DMAC data bytes.
- Stops requesting on EOP until software clears it.

---
 rtl/dma_io_pkg.sv | 21 ++
 rtl/dma_io_if.sv | 26 ++
 rtl/dma_io_fifo.sv | 60 ++++++
 rtl/dma_io_port.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/dma_io_pkg.sv
// Shared types and defaults for the DMA I/O port.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dma_io_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACT,
        ST_DONE
    } state_e;

    localparam logic DIR_DEV2MEM = 1'b0;   // DMAC reads bytes via IOR
    localparam logic DIR_MEM2DEV = 1'b1;   // DMAC writes bytes via IOW

    localparam int DATA_W              = 8;
    localparam int DEFAULT_DEPTH       = 8;
    localparam int DEFAULT_REQ_LEVEL   = 4;
    localparam int DEFAULT_TIMEOUT_CYC = 64;

endpackage

// File: rtl/dma_io_if.sv
// DMAC device-side bus: request/acknowledge, strobes, EOP, ready and data bytes.
// Latency: n/a (wires only); the slave modport is the I/O port, master is the DMAC.
// Backpressure: rdy is the wait-state line from the port to the DMAC.
interface dma_io_if;
    import dma_io_pkg::*;

    logic              dreq;
    logic              dack;
    logic              ior;
    logic              iow;
    logic              eop;
    logic              rdy;
    logic [DATA_W-1:0] io_data_out;
    logic [DATA_W-1:0] io_data_in;

    modport slave (
        output dreq, rdy, io_data_out,
        input  dack, ior, iow, eop, io_data_in
    );

    modport master (
        input  dreq, rdy, io_data_out,
        output dack, ior, iow, eop, io_data_in
    );

endinterface

// File: rtl/dma_io_fifo.sv
// Synchronous show-ahead byte FIFO with occupancy count and drop indications.
// Latency: push visible at the head one cycle later; rdata_o reads 0 while empty.
// Backpressure: push when full is dropped (push_drop_o) unless a pop frees a slot
//   in the same cycle; pop when empty is ignored (pop_drop_o).
// Ports: clk_i/rst_n_i, push_i/wdata_i, pop_i, rdata_o, count_o, full_o, empty_o,
//   push_drop_o/pop_drop_o (single-cycle pulses).
module dma_io_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [W-1:0]             wdata_i,
    input  logic                     pop_i,
    output logic [W-1:0]             rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     push_drop_o,
    output logic                     pop_drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);

    // A pop at full frees the slot the simultaneous push lands in; a push at
    // empty is never bypassed to a simultaneous pop.
    assign do_pop      = pop_i && !empty_o;
    assign do_push     = push_i && (!full_o || do_pop);
    assign push_drop_o = push_i && !do_push;
    assign pop_drop_o  = pop_i && empty_o;

    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/dma_io_port.sv
// DMA I/O port: buffers bytes between a device push/pop side and a DMAC channel.
// Latency: DREQ rises two edges after the FIFO reaches the request level; IOR pops
//   and IOW pushes take effect on the edge after the strobe falls.
// Backpressure: RDY (wait state) follows FIFO empty/full; device pushes into a full
//   FIFO are dropped and flagged in OVF, pops from empty flagged in UNF.
// Ports: clk_i/rst_n_i, dir_i, clr_i, device side dev_*, status count_o/ovf_o/unf_o/
//   tmo_o, DMAC side via dma_io_if.slave.
// Optional: define DMA_IO_TIMEOUT_EN to abandon a request left unacknowledged for
//   TIMEOUT_CYC cycles (sets TMO); otherwise REQ waits forever and TMO reads 0.
module dma_io_port
    import dma_io_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int REQ_LEVEL   = DEFAULT_REQ_LEVEL,
    parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   dir_i,
    input  logic                   clr_i,
    input  logic                   dev_wr_i,
    input  logic [DATA_W-1:0]      dev_wdata_i,
    input  logic                   dev_rd_i,
    output logic [DATA_W-1:0]      dev_rdata_o,
    output logic                   dev_full_o,
    output logic                   dev_empty_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   ovf_o,
    output logic                   unf_o,
    output logic                   tmo_o,
    dma_io_if.slave                dma
);
    localparam int CW = $clog2(DEPTH) + 1;

    state_e            state_q, state_d;
    logic              dreq_q, dreq_d;
    logic              dir_q;
    logic              ior_q, iow_q, dack_q;
    logic [DATA_W-1:0] hold_q;
    logic              ovf_q, unf_q;

    logic              dma_en, pop_dma, push_dma;
    logic              fifo_push, fifo_pop, push_drop, pop_drop;
    logic [DATA_W-1:0] fifo_wdata, head;
    logic              level_ok, xfer_done, tmo_hit;

    // DMA strobes act on their falling edge and only if DACK was high during
    // the strobe's last cycle; DONE locks the DMAC side out entirely.
    assign dma_en   = (state_q != ST_DONE);
    assign pop_dma  = (dir_q == DIR_DEV2MEM) && dma_en && ior_q && !dma.ior && dack_q;
    assign push_dma = (dir_q == DIR_MEM2DEV) && dma_en && iow_q && !dma.iow && dack_q;

    assign fifo_push  = (dir_q == DIR_DEV2MEM) ? dev_wr_i    : push_dma;
    assign fifo_pop   = (dir_q == DIR_DEV2MEM) ? pop_dma     : dev_rd_i;
    assign fifo_wdata = (dir_q == DIR_DEV2MEM) ? dev_wdata_i : hold_q;

    dma_io_fifo #(.DEPTH(DEPTH), .W(DATA_W)) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (fifo_push),
        .wdata_i     (fifo_wdata),
        .pop_i       (fifo_pop),
        .rdata_o     (head),
        .count_o     (count_o),
        .full_o      (dev_full_o),
        .empty_o     (dev_empty_o),
        .push_drop_o (push_drop),
        .pop_drop_o  (pop_drop)
    );

    assign dev_rdata_o     = head;
    assign dma.io_data_out = head;
    assign dma.dreq        = dreq_q;
    assign dma.rdy         = (state_q == ST_IDLE || state_q == ST_DONE) ? 1'b0 :
                             (dir_q == DIR_DEV2MEM) ? !dev_empty_o : !dev_full_o;

    assign level_ok  = (dir_q == DIR_DEV2MEM) ? (count_o >= CW'(REQ_LEVEL))
                                              : ((CW'(DEPTH) - count_o) >= CW'(REQ_LEVEL));
    assign xfer_done = (dir_q == DIR_DEV2MEM) ? dev_empty_o : dev_full_o;

`ifdef DMA_IO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_q;
    logic          tmo_q;

    assign tmo_hit = (state_q == ST_REQ) && !dma.dack && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
    assign tmo_o   = tmo_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= (state_q == ST_REQ && !dma.dack && !tmo_hit) ? tmo_cnt_q + 1'b1 : '0;
            tmo_q     <= (tmo_q && !clr_i) || tmo_hit;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_o   = 1'b0;
`endif

    // DREQ is registered: it reflects the state of the previous cycle, so it
    // rises one edge after the FSM enters REQ.
    always_comb begin
        state_d = state_q;
        dreq_d  = 1'b0;
        case (state_q)
            ST_IDLE: if (level_ok) state_d = ST_REQ;
            ST_REQ: begin
                dreq_d = 1'b1;
                if (dma.dack) begin
                    state_d = ST_ACT;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    dreq_d  = 1'b0;
                end
            end
            ST_ACT: begin
                // Once dropped, DREQ stays low for the rest of this transfer.
                dreq_d = dreq_q && !xfer_done;
                if (!dreq_q && !dma.dack) state_d = ST_IDLE;
            end
            // DONE is the EOP latch: it holds until software clears it.
            ST_DONE: if (clr_i) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (dma.eop) begin
            state_d = ST_DONE;
            dreq_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            dreq_q  <= 1'b0;
            dir_q   <= DIR_DEV2MEM;
            ior_q   <= 1'b0;
            iow_q   <= 1'b0;
            dack_q  <= 1'b0;
            hold_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dreq_q  <= dreq_d;
            if (state_q == ST_IDLE || state_q == ST_DONE) dir_q <= dir_i;
            ior_q   <= dma.ior;
            iow_q   <= dma.iow;
            dack_q  <= dma.dack;
            if (dir_q == DIR_MEM2DEV && dma_en && dma.iow && dma.dack) hold_q <= dma.io_data_in;
            ovf_q   <= (ovf_q && !clr_i) || push_drop;
            unf_q   <= (unf_q && !clr_i) || pop_drop;
        end
    end

    assign ovf_o = ovf_q;
    assign unf_o = unf_q;

endmodule
